// File: rtl/nand_nor_pkg.sv
// rtl/nand_nor_pkg.sv - shared FSM states, vector count and golden gate functions
package nand_nor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int NUM_VEC = 4;

    function automatic logic golden_nand(input logic a, input logic b);
        return ~(a & b);
    endfunction

    function automatic logic golden_nor(input logic a, input logic b);
        return ~(a | b);
    endfunction

endpackage

// File: rtl/nand_nor_ref.sv
// rtl/nand_nor_ref.sv - combinational golden model of the NAND/NOR cell
module nand_nor_ref
    import nand_nor_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic t0,
    output logic t1
);

    assign t0 = golden_nand(a, b);
    assign t1 = golden_nor(a, b);

endmodule

// File: rtl/nand_nor_checker.sv
// rtl/nand_nor_checker.sv - drives all four a/b vectors into a NAND/NOR cell and checks t0/t1
module nand_nor_checker
    import nand_nor_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               a,
    output logic               b,
    input  logic               t0,
    input  logic               t1,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_cnt,
    output logic [NUM_VEC-1:0] fail_vec
);

    localparam int                CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0]        VEC_LAST = 2'(NUM_VEC - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

    state_t              state, state_nxt;
    logic [1:0]          vec, vec_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                a_q, a_nxt;
    logic                b_q, b_nxt;
    logic                pass_q, pass_nxt;
    logic [ERR_W-1:0]    err_q, err_nxt;
    logic [NUM_VEC-1:0]  fail_q, fail_nxt;

    logic                exp_t0, exp_t1;
    logic [1:0]          mism_num;
    logic [ERR_W:0]      err_sum;
    logic [ERR_W-1:0]    err_sat;

    nand_nor_ref u_ref (
        .a  (a_q),
        .b  (b_q),
        .t0 (exp_t0),
        .t1 (exp_t1)
    );

    // Each mismatching output bit counts once; the total saturates rather than wraps.
    assign mism_num = {1'b0, (t0 != exp_t0)} + {1'b0, (t1 != exp_t1)};
    assign err_sum  = {1'b0, err_q} + (ERR_W + 1)'(mism_num);
    assign err_sat  = err_sum[ERR_W] ? ERR_MAX : err_sum[ERR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            vec    <= '0;
            cnt    <= '0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            pass_q <= 1'b0;
            err_q  <= '0;
            fail_q <= '0;
        end else begin
            state  <= state_nxt;
            vec    <= vec_nxt;
            cnt    <= cnt_nxt;
            a_q    <= a_nxt;
            b_q    <= b_nxt;
            pass_q <= pass_nxt;
            err_q  <= err_nxt;
            fail_q <= fail_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        vec_nxt   = vec;
        cnt_nxt   = cnt;
        a_nxt     = a_q;
        b_nxt     = b_q;
        pass_nxt  = pass_q;
        err_nxt   = err_q;
        fail_nxt  = fail_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    err_nxt   = '0;
                    fail_nxt  = '0;
                    pass_nxt  = 1'b0;
                    vec_nxt   = '0;
                    a_nxt     = 1'b0;
                    b_nxt     = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = ST_SAMPLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_SAMPLE: begin
                err_nxt = err_sat;
                if (mism_num != 2'd0) begin
                    fail_nxt[vec] = 1'b1;
                end
                if (vec == VEC_LAST) begin
                    // pass is resolved on DONE entry so it is valid alongside the done pulse
                    pass_nxt  = (err_sat == '0);
                    a_nxt     = 1'b0;
                    b_nxt     = 1'b0;
                    state_nxt = ST_DONE;
                end else begin
                    vec_nxt          = vec + 1'b1;
                    {a_nxt, b_nxt}   = vec + 1'b1;
                    cnt_nxt          = '0;
                    state_nxt        = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign a        = a_q;
    assign b        = b_q;
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign pass     = pass_q;
    assign err_cnt  = err_q;
    assign fail_vec = fail_q;

endmodule

// File: tb/tb_nand_nor_checker.sv
// tb/tb_nand_nor_checker.sv - directed-vector bench for nand_nor_checker
module tb_nand_nor_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    int         mode = 0;

    logic       a0, b0, t0_0, t1_0, busy0, done0, pass0;
    logic [3:0] err0, fail0;
    logic       a1, b1, t0_1, t1_1, busy1, done1, pass1;
    logic [3:0] err1, fail1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // mode 0: correct cell, 1: t0 stuck at 1, 2: t0/t1 swapped
    assign t0_0 = (mode == 1) ? 1'b1 : (mode == 2) ? ~(a0 | b0) : ~(a0 & b0);
    assign t1_0 = (mode == 2) ? ~(a0 & b0) : ~(a0 | b0);
    assign t0_1 = ~(a1 & b1);
    assign t1_1 = ~(a1 | b1);

    nand_nor_checker #(.SETTLE_CYCLES(2), .ERR_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .t0(t0_0), .t1(t1_0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_vec(fail0)
    );

    nand_nor_checker #(.SETTLE_CYCLES(1), .ERR_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .t0(t0_1), .t1(t1_1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_vec(fail1)
    );

    // Cycle numbering: the accepting edge E is cycle 0's end; the period after edge E+k is cycle k+1.
    task automatic run0(input int restart_at, input bit hold, input int ncyc,
                        output int first_done, output int second_done, output int n_done,
                        output logic pass_e, output logic busy_post);
        first_done  = -1;
        second_done = -1;
        n_done      = 0;
        busy_post   = 1'b1;
        start0 = 1'b1;
        @(posedge clk); #1;
        pass_e = pass0;
        start0 = hold;
        for (int c = 1; c <= ncyc; c++) begin
            start0 = hold || (c == restart_at);
            @(posedge clk); #1;
            if (done0) begin
                n_done++;
                if (first_done < 0) first_done = c + 1;
                else if (second_done < 0) second_done = c + 1;
            end
            if (first_done >= 0 && c + 1 == first_done + 1) busy_post = busy0;
        end
        start0 = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        n_tests++; if (a0 !== 1'b0)     begin n_fail++; $display("FAIL reset_a: got %b want 0", a0); end
        n_tests++; if (b0 !== 1'b0)     begin n_fail++; $display("FAIL reset_b: got %b want 0", b0); end
        n_tests++; if (busy0 !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy0); end
        n_tests++; if (done0 !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b want 0", done0); end
        n_tests++; if (pass0 !== 1'b0)  begin n_fail++; $display("FAIL reset_pass: got %b want 0", pass0); end
        n_tests++; if (err0 !== 4'd0)   begin n_fail++; $display("FAIL reset_err: got %0d want 0", err0); end
        n_tests++; if (fail0 !== 4'b0)  begin n_fail++; $display("FAIL reset_fail_vec: got %b want 0000", fail0); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_clean;
        int fd, sd, nd; logic pe, bp;
        mode = 0;
        run0(0, 1'b0, 20, fd, sd, nd, pe, bp);
        n_tests++; if (fd !== 13)      begin n_fail++; $display("FAIL clean_done_cycle: got %0d want 13", fd); end
        n_tests++; if (nd !== 1)       begin n_fail++; $display("FAIL clean_done_count: got %0d want 1", nd); end
        n_tests++; if (bp !== 1'b0)    begin n_fail++; $display("FAIL clean_busy_after_done: got %b want 0", bp); end
        n_tests++; if (pass0 !== 1'b1) begin n_fail++; $display("FAIL clean_pass: got %b want 1", pass0); end
        n_tests++; if (err0 !== 4'd0)  begin n_fail++; $display("FAIL clean_err: got %0d want 0", err0); end
        n_tests++; if (fail0 !== 4'b0) begin n_fail++; $display("FAIL clean_fail_vec: got %b want 0000", fail0); end
    endtask

    task automatic test_restart_ignored;
        int fd, sd, nd; logic pe, bp;
        mode = 0;
        // start re-asserted so that edge E+4 (vector 1 SETTLE) sees it
        run0(4, 1'b0, 24, fd, sd, nd, pe, bp);
        n_tests++; if (pe !== 1'b0)    begin n_fail++; $display("FAIL restart_pass_cleared: got %b want 0", pe); end
        n_tests++; if (fd !== 13)      begin n_fail++; $display("FAIL restart_done_cycle: got %0d want 13", fd); end
        n_tests++; if (nd !== 1)       begin n_fail++; $display("FAIL restart_done_count: got %0d want 1", nd); end
        n_tests++; if (pass0 !== 1'b1) begin n_fail++; $display("FAIL restart_pass: got %b want 1", pass0); end
        n_tests++; if (err0 !== 4'd0)  begin n_fail++; $display("FAIL restart_err: got %0d want 0", err0); end
    endtask

    task automatic test_t0_stuck;
        int fd, sd, nd; logic pe, bp;
        mode = 1;
        run0(0, 1'b0, 20, fd, sd, nd, pe, bp);
        n_tests++; if (fd !== 13)         begin n_fail++; $display("FAIL stuck_done_cycle: got %0d want 13", fd); end
        n_tests++; if (pass0 !== 1'b0)    begin n_fail++; $display("FAIL stuck_pass: got %b want 0", pass0); end
        n_tests++; if (err0 !== 4'd1)     begin n_fail++; $display("FAIL stuck_err: got %0d want 1", err0); end
        n_tests++; if (fail0 !== 4'b1000) begin n_fail++; $display("FAIL stuck_fail_vec: got %b want 1000", fail0); end
    endtask

    task automatic test_swapped;
        int fd, sd, nd; logic pe, bp;
        mode = 2;
        run0(0, 1'b0, 20, fd, sd, nd, pe, bp);
        n_tests++; if (pass0 !== 1'b0)    begin n_fail++; $display("FAIL swap_pass: got %b want 0", pass0); end
        n_tests++; if (err0 !== 4'd4)     begin n_fail++; $display("FAIL swap_err: got %0d want 4", err0); end
        n_tests++; if (fail0 !== 4'b0110) begin n_fail++; $display("FAIL swap_fail_vec: got %b want 0110", fail0); end
    endtask

    task automatic test_mid_reset;
        int fd, sd, nd; logic pe, bp;
        int rd;
        mode = 2;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
        end
        n_tests++; if ({a0, b0} !== 2'b10) begin n_fail++; $display("FAIL midrst_vec2_ab: got %b want 10", {a0, b0}); end
        rst_n = 1'b0;
        #1;
        n_tests++; if ({a0, b0} !== 2'b00) begin n_fail++; $display("FAIL midrst_ab: got %b want 00", {a0, b0}); end
        n_tests++; if (busy0 !== 1'b0)     begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy0); end
        n_tests++; if (err0 !== 4'd0)      begin n_fail++; $display("FAIL midrst_err: got %0d want 0", err0); end
        n_tests++; if (fail0 !== 4'b0)     begin n_fail++; $display("FAIL midrst_fail_vec: got %b want 0000", fail0); end
        rd = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (done0) rd++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            if (done0) rd++;
        end
        n_tests++; if (rd !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses want 0", rd); end
        mode = 0;
        run0(0, 1'b0, 20, fd, sd, nd, pe, bp);
        n_tests++; if (fd !== 13)      begin n_fail++; $display("FAIL midrst_rerun_done: got %0d want 13", fd); end
        n_tests++; if (pass0 !== 1'b1) begin n_fail++; $display("FAIL midrst_rerun_pass: got %b want 1", pass0); end
    endtask

    task automatic test_back_to_back;
        int fd, sd, nd; logic pe, bp;
        mode = 0;
        run0(0, 1'b1, 27, fd, sd, nd, pe, bp);
        n_tests++; if (fd !== 13)      begin n_fail++; $display("FAIL b2b_first_done: got %0d want 13", fd); end
        n_tests++; if (sd !== 27)      begin n_fail++; $display("FAIL b2b_second_done: got %0d want 27", sd); end
        n_tests++; if (nd !== 2)       begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", nd); end
        n_tests++; if (pass0 !== 1'b1) begin n_fail++; $display("FAIL b2b_pass: got %b want 1", pass0); end
        n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after: got %b want 0", busy0); end
    endtask

    task automatic test_settle_one;
        logic [15:0] ab_hist;
        int          fd;
        fd = -1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        ab_hist = {14'b0, a1, b1};
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c <= 7) ab_hist = {ab_hist[13:0], a1, b1};
            if (done1 && fd < 0) fd = c + 1;
        end
        n_tests++; if (fd !== 9)      begin n_fail++; $display("FAIL s1_done_cycle: got %0d want 9", fd); end
        n_tests++; if (ab_hist !== 16'b0000_0101_1010_1111)
            begin n_fail++; $display("FAIL s1_ab_sequence: got %b want 0000010110101111", ab_hist); end
        n_tests++; if (pass1 !== 1'b1) begin n_fail++; $display("FAIL s1_pass: got %b want 1", pass1); end
        n_tests++; if (err1 !== 4'd0)  begin n_fail++; $display("FAIL s1_err: got %0d want 0", err1); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_restart_ignored();
        test_t0_stuck();
        test_swapped();
        test_mid_reset();
        test_back_to_back();
        test_settle_one();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
